// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_pkg
// Description : Shared mode constants and state encoding for the registered
//               binary-to-one-hot decoder with walk mode.
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

  // Operating mode encoding on the mode input
  localparam logic MODE_DEC  = 1'b0;
  localparam logic MODE_WALK = 1'b1;

  // Controller states; IDLE is the reset and disabled state
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DEC  = 2'b01,
    ST_WALK = 2'b10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/decoder_nto2n_seq_bin2onehot.sv
`default_nettype none
// ============================================================================
// Module      : bin2onehot
// Description : Combinational SEL_W-bit binary to 2^SEL_W one-hot converter
//               with an optional mask that suppresses output bit 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2onehot #(
  parameter int unsigned SEL_W = 3,
  localparam int unsigned OUT_W = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             mask0_i,
  output logic [OUT_W-1:0] y_o
);

  // One comparator per output line; bit 0 can be gated off so that a
  // masked position decodes to all-zero rather than a forbidden line.
  for (genvar i = 0; i < OUT_W; i++) begin : g_bit
    if (i == 0) begin : g_lsb
      assign y_o[i] = (sel_i == '0) & ~mask0_i;
    end else begin : g_upper
      assign y_o[i] = (sel_i == SEL_W'(i));
    end
  end

endmodule
`default_nettype wire

// File: rtl/decoder_nto2n_seq.sv
`default_nettype none
// ============================================================================
// Module      : decoder_nto2n_seq
// Description : Registered binary-to-one-hot decoder. DEC mode registers the
//               one-hot image of sel; WALK mode steps a single hot bit around
//               all outputs, reloading from sel on entry or on load. Optional
//               zero-masking keeps output bit 0 permanently low.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_nto2n_seq
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W     = 3,   // legal range 1..6
  parameter int unsigned ZERO_MASK = 0,
  localparam int unsigned OUT_W    = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             load,
  output logic [OUT_W-1:0] y,
  output logic [SEL_W-1:0] idx,
  output logic             valid,
  output logic             wrap
);

  localparam logic [SEL_W-1:0] IDX_LAST = '1;
  localparam logic [SEL_W-1:0] IDX_ONE  = SEL_W'(1);
  localparam logic             MASK0    = (ZERO_MASK != 0);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   idx_q,   idx_d;
  logic [OUT_W-1:0]   y_q,     y_d;
  logic               valid_q, valid_d;
  logic               wrap_q,  wrap_d;
  logic [OUT_W-1:0]   onehot_next;

  // The output image is always derived from the position being registered,
  // so y and idx can never disagree.
  bin2onehot #(
    .SEL_W (SEL_W)
  ) u_bin2onehot (
    .sel_i   (idx_d),
    .mask0_i (MASK0),
    .y_o     (onehot_next)
  );

  // Next-state, next-position and output decode in priority order
  always_comb begin
    state_d = ST_IDLE;
    idx_d   = idx_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (!en) begin
      // Disabled: outputs drop, position is remembered but not reused
      state_d = ST_IDLE;
    end else if (mode == MODE_DEC) begin
      state_d = ST_DEC;
      idx_d   = sel;
      valid_d = 1'b1;
    end else if ((state_q != ST_WALK) || load) begin
      // Any entry into WALK reloads the start position; a masked start of 0
      // is moved to the first legal position.
      state_d = ST_WALK;
      idx_d   = (MASK0 && (sel == '0)) ? IDX_ONE : sel;
      valid_d = 1'b1;
    end else begin
      state_d = ST_WALK;
      valid_d = 1'b1;
      if (idx_q == IDX_LAST) begin
        wrap_d = 1'b1;
        idx_d  = MASK0 ? IDX_ONE : '0;
      end else begin
        idx_d  = idx_q + IDX_ONE;
      end
    end
    y_d = valid_d ? onehot_next : '0;
  end

  // State and output flops with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign y     = y_q;
  assign idx   = idx_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_nto2n_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_nto2n_seq
// Description : Self-checking bench for decoder_nto2n_seq. Five instances with
//               different SEL_W / ZERO_MASK share one stimulus stream; a
//               behavioural model pushes expected outputs to a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_nto2n_seq;

  typedef struct packed {
    logic [4:0][63:0] y;
    logic [4:0][5:0]  idx;
    logic [4:0]       v;
    logic [4:0]       w;
  } exp_t;

  logic       clk;
  logic       rst, en, mode, load;
  logic [5:0] sel;

  logic [7:0]  y0;  logic [2:0] idx0;
  logic [3:0]  y1;  logic [1:0] idx1;
  logic [1:0]  y2;  logic [0:0] idx2;
  logic [1:0]  y3;  logic [0:0] idx3;
  logic [63:0] y4;  logic [5:0] idx4;
  logic [4:0]  ov, ow;

  logic [4:0][63:0] oy;
  logic [4:0][5:0]  oi;

  assign oy[0] = {56'b0, y0};  assign oi[0] = {3'b0, idx0};
  assign oy[1] = {60'b0, y1};  assign oi[1] = {4'b0, idx1};
  assign oy[2] = {62'b0, y2};  assign oi[2] = {5'b0, idx2};
  assign oy[3] = {62'b0, y3};  assign oi[3] = {5'b0, idx3};
  assign oy[4] = y4;           assign oi[4] = idx4;

  decoder_nto2n_seq #(.SEL_W(3), .ZERO_MASK(0)) u_d0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[2:0]), .load(load),
    .y(y0), .idx(idx0), .valid(ov[0]), .wrap(ow[0]));
  decoder_nto2n_seq #(.SEL_W(2), .ZERO_MASK(1)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[1:0]), .load(load),
    .y(y1), .idx(idx1), .valid(ov[1]), .wrap(ow[1]));
  decoder_nto2n_seq #(.SEL_W(1), .ZERO_MASK(0)) u_d2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[0:0]), .load(load),
    .y(y2), .idx(idx2), .valid(ov[2]), .wrap(ow[2]));
  decoder_nto2n_seq #(.SEL_W(1), .ZERO_MASK(1)) u_d3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[0:0]), .load(load),
    .y(y3), .idx(idx3), .valid(ov[3]), .wrap(ow[3]));
  decoder_nto2n_seq #(.SEL_W(6), .ZERO_MASK(0)) u_d4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .load(load),
    .y(y4), .idx(idx4), .valid(ov[4]), .wrap(ow[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  // Model state per instance: st 0=IDLE 1=DEC 2=WALK
  int SW [5] = '{3, 2, 1, 1, 6};
  int ZM [5] = '{0, 1, 0, 1, 0};
  int m_st  [5] = '{0, 0, 0, 0, 0};
  int m_idx [5] = '{0, 0, 0, 0, 0};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, push the model's prediction, then compare
  task automatic step(input bit r, input bit e, input bit m, input int s, input bit l);
    exp_t ex;
    exp_t got;
    int   n;
    int   sk;
    rst  = r;
    en   = e;
    mode = m;
    sel  = 6'(s);
    load = l;
    ex   = '0;
    for (int k = 0; k < 5; k++) begin
      n  = 1 << SW[k];
      sk = s & (n - 1);
      if (r) begin
        m_st[k]  = 0;
        m_idx[k] = 0;
      end else if (!e) begin
        m_st[k] = 0;
      end else if (!m) begin
        m_st[k]  = 1;
        m_idx[k] = sk;
        ex.v[k]  = 1'b1;
        ex.y[k]  = (ZM[k] != 0 && sk == 0) ? 64'd0 : (64'd1 << sk);
      end else if (m_st[k] != 2 || l) begin
        m_st[k]  = 2;
        m_idx[k] = (ZM[k] != 0 && sk == 0) ? 1 : sk;
        ex.v[k]  = 1'b1;
        ex.y[k]  = 64'd1 << m_idx[k];
      end else begin
        ex.v[k] = 1'b1;
        if (m_idx[k] == n - 1) begin
          ex.w[k]  = 1'b1;
          m_idx[k] = (ZM[k] != 0) ? 1 : 0;
        end else begin
          m_idx[k] = m_idx[k] + 1;
        end
        ex.y[k] = 64'd1 << m_idx[k];
      end
      ex.idx[k] = 6'(m_idx[k]);
    end
    sb.push_back(ex);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("y[%0d]", k),     oy[k],        got.y[k]);
      chk($sformatf("idx[%0d]", k),   64'(oi[k]),   64'(got.idx[k]));
      chk($sformatf("valid[%0d]", k), 64'(ov[k]),   64'(got.v[k]));
      chk($sformatf("wrap[%0d]", k),  64'(ow[k]),   64'(got.w[k]));
      chk($sformatf("hot1[%0d]", k),  64'($countones(oy[k]) <= 1), 64'd1);
    end
  endtask

  int wraps;

  initial begin
    // Reset held with enable and a live select
    step(1, 1, 0, 5, 0);
    step(1, 1, 0, 5, 0);
    chk("rst_y0", oy[0], 64'h0);
    step(0, 1, 0, 5, 0);
    chk("rel_y0", oy[0], 64'h20);

    // DEC sweep then disable
    for (int s = 0; s < 8; s++) step(0, 1, 0, s, 0);
    step(0, 0, 0, 0, 0);
    chk("dis_idx0", 64'(oi[0]), 64'd7);

    // WALK wrap from 6
    step(0, 1, 1, 6, 0); chk("w6_a", oy[0], 64'h40);
    step(0, 1, 1, 0, 0); chk("w6_b", oy[0], 64'h80);
    step(0, 1, 1, 0, 0); chk("w6_c", oy[0], 64'h01); chk("w6_wr", 64'(ow[0]), 64'd1);
    step(0, 1, 1, 0, 0); chk("w6_d", oy[0], 64'h02);

    // Zero-masked 2-bit instance
    step(0, 1, 0, 0, 0); chk("zm_dec_y", oy[1], 64'h0); chk("zm_dec_v", 64'(ov[1]), 64'd1);
    step(0, 1, 1, 0, 0); chk("zm_w_a", oy[1], 64'h2);
    step(0, 1, 1, 0, 0); chk("zm_w_b", oy[1], 64'h4);
    step(0, 1, 1, 0, 0); chk("zm_w_c", oy[1], 64'h8);
    step(0, 1, 1, 0, 0); chk("zm_w_d", oy[1], 64'h2); chk("zm_w_wr", 64'(ow[1]), 64'd1);

    // Load mid-walk, mode switch, reset mid-walk
    step(0, 0, 1, 3, 0);
    step(0, 1, 1, 3, 0);
    step(0, 1, 1, 3, 0);
    step(0, 1, 1, 3, 0); chk("mid_idx5", 64'(oi[0]), 64'd5);
    step(0, 1, 1, 2, 1); chk("ld_y", oy[0], 64'h04);
    step(0, 1, 1, 2, 0); chk("ld_adv", oy[0], 64'h08);
    step(0, 1, 0, 7, 0); chk("sw_dec", oy[0], 64'h80);
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0);
    step(1, 1, 1, 1, 0); chk("rst_mid", oy[0], 64'h0);

    // en dropped and restored during a walk reloads sel
    step(0, 1, 1, 4, 0);
    step(0, 1, 1, 4, 0);
    step(0, 0, 1, 4, 0);
    step(0, 1, 1, 6, 0); chk("reen_y", oy[0], 64'h40);

    // load held high behaves like DEC
    for (int s = 0; s < 4; s++) step(0, 1, 1, 2 * s + 1, 1);

    // Full revolution of the 64-output instance
    step(0, 1, 1, 0, 0);
    wraps = 0;
    for (int c = 0; c < 64; c++) begin
      step(0, 1, 1, 0, 0);
      if (ow[4]) wraps++;
    end
    chk("wrap64", 64'(wraps), 64'd1);

    // Randomised traffic against the model
    for (int c = 0; c < 300; c++) begin
      step($urandom_range(0, 31) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 2) != 0, int'($urandom_range(0, 63)),
           $urandom_range(0, 5) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decoder_nto2n_seq.md
# decoder_nto2n_seq

Parametrised, registered binary-to-one-hot decoder with a second, sequential mode.
- Decode mode: registers the one-hot image of a SEL_W-bit select.
- Walk mode: a ring counter steps a single hot bit across all 2^SEL_W outputs, for scan/sweep duties.
- Optional zero-masking keeps output bit 0 permanently low, so the block can drive register-file write enables where x0 is never written.
- Sits between control logic and any bank of 2^SEL_W enable lines; replaces the fixed 3-to-8 combinational decoder where registered or scanning behaviour is needed.

## Interface
Parameters:
- SEL_W, default 3: select width. Legal range 1..6.
- ZERO_MASK, default 0: when 1, output bit 0 is never asserted.
- OUT_W: derived localparam, 2**SEL_W. Not overridable.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable.
- mode  in  1  operating mode. 0 = DEC, 1 = WALK.
- sel  in  SEL_W  decode select in DEC; start position in WALK.
- load  in  1  in WALK, forces a reload of the position from sel.
- y  out  OUT_W  registered one-hot (or all-zero) output.
- idx  out  SEL_W  registered binary position matching y.
- valid  out  1  y holds a decode or walk result (state ≠ IDLE).
- wrap  out  1  one-cycle pulse when the walk position wraps.

## Operation
States:
- IDLE: entered on rst or en=0.
- DEC: entered on en=1 with mode=0.
- WALK: entered on en=1 with mode=1.

Per rising edge, in priority order:
1. rst=1: state←IDLE, idx←0, y←0, valid←0, wrap←0.
2. en=0: state←IDLE, y←0, valid←0, wrap←0; idx holds its value.
3. mode=0: state←DEC, idx←sel, y←onehot(sel), valid←1, wrap←0.
4. mode=1 and (state≠WALK or load=1): state←WALK, idx←sel, y←onehot(sel), valid←1, wrap←0. Entry into WALK always loads sel, regardless of load.
5. mode=1, state=WALK, load=0: idx←idx+1 mod OUT_W, y←onehot(idx+1), wrap←1 iff idx was OUT_W−1, else wrap←0.

Zero masking and legal values:
- onehot(k) = 1<<k.
- With ZERO_MASK=1, position 0 is illegal in y.
  - DEC with sel=0: y←0, idx←0, valid←1.
  - WALK load with sel=0: loads idx←1 instead.
  - WALK advance from OUT_W−1: goes to 1, not 0; wrap still pulses.
- y is always one-hot or all-zero. Never more than one bit set.
- Arithmetic is unsigned, modulo 2^SEL_W. No X propagation: every register is assigned in every branch.

## Timing
- Latency: exactly 1 cycle from sampled en/mode/sel/load to y/idx/valid.
- Outputs are pure flops; there is no combinational path from input to output.
- Reset values: y=0, idx=0, valid=0, wrap=0, state=IDLE.
- Reset mid-walk: the next edge gives all outputs zero.
- Walk period: OUT_W cycles per revolution, or OUT_W−1 with ZERO_MASK=1. wrap is high for exactly one cycle per revolution, coincident with y at the first position.
- Mode change WALK→DEC: takes effect on the next edge. Walk progress is lost; returning to WALK reloads sel.
- en dropped then restored in WALK: the block reloads sel, not the old idx.
- load held high in WALK: y is re-decoded from sel every cycle with no advance, i.e. behaves like DEC.
- SEL_W=1, ZERO_MASK=0: y alternates 01/10 and wrap pulses every 2nd cycle.
- SEL_W=1, ZERO_MASK=1: y stays 10 and wrap pulses every cycle after the first advance.

## Structure
- Shared package decoder_pkg holds:
  - mode constants MODE_DEC=1'b0 and MODE_WALK=1'b1;
  - state typedef {ST_IDLE, ST_DEC, ST_WALK}, 2 bits.
- One combinational sub-module, bin2onehot (parameter SEL_W, plus mask-bit-0 input), computes y_next from the next idx.
- The top level holds the state register, idx register, wrap logic and output flops.

## Test plan
- Reset: rst=1 for 2 cycles while en=1, mode=0, sel=5 → y=0, idx=0, valid=0, wrap=0. After release, the next edge gives y=8'b0010_0000, valid=1.
- DEC sweep (SEL_W=3): sel=0..7 on consecutive cycles with en=1 → y = 1<<sel one cycle later, idx=sel. Then en=0 → y=0, valid=0 next cycle, idx holds 7.
- WALK wrap (SEL_W=3): mode=1, sel=6 → y sequence 0x40, 0x80, 0x01, 0x02; wrap=1 only in the 0x01 cycle.
- ZERO_MASK=1, SEL_W=2:
  - DEC sel=0 → y=0, valid=1.
  - WALK from sel=0 → y 0010, 0100, 1000, 0010, with wrap on the second 0010.
- Mid-operation events (SEL_W=3):
  - load=1, sel=2 during a walk at idx=5 → y=0x04 next cycle, then 0x08.
  - Switch to mode=0, sel=7 → y=0x80.
  - rst asserted during a walk → all outputs 0 on the next edge.
- Parameter corners:
  - SEL_W=1: walk alternates 01/10 with wrap every 2nd cycle.
  - SEL_W=6: walk of 64 cycles with exactly one wrap; y one-hot checked every cycle.
